// File: rtl/issue_queue_pkg.sv
// Shared types for the issue queue: the fetch->issue pipeline payload.
package issue_queue_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } pipe_in_t;

endpackage

// File: rtl/issue_queue_if.sv
// Enqueue/dequeue handshake bundle between fetch, the issue queue and dispatch.
interface issue_queue_if;
    import issue_queue_pkg::*;

    logic     enq_valid;
    pipe_in_t enq_data;
    logic     queue_full;
    logic     deq_valid;
    pipe_in_t deq_data;
    logic     deq_ready;

    modport master (
        output enq_valid, enq_data, deq_ready,
        input  queue_full, deq_valid, deq_data
    );

    modport slave (
        input  enq_valid, enq_data, deq_ready,
        output queue_full, deq_valid, deq_data
    );
endinterface

// File: rtl/issue_queue.sv
// Circular-buffer issue queue with first-word-fall-through head, skid-aware
// back-pressure, sticky overflow detection and synchronous flush.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int SKID  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    issue_queue_if.slave               q,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    pipe_in_t        mem_r [DEPTH];
    logic [PW-1:0]   head_r;
    logic [PW-1:0]   tail_r;
    logic [CW-1:0]   count_r;
    logic            overflow_r;

    logic            deq_fire_s;
    logic            enq_fire_s;
    logic            drop_s;

    // Handshake decode; a dequeue frees a slot so a full queue still accepts.
    always_comb begin
        deq_fire_s = 1'b0;
        enq_fire_s = 1'b0;
        drop_s     = 1'b0;
        if (q.deq_valid && q.deq_ready) begin
            deq_fire_s = 1'b1;
        end else begin
            deq_fire_s = 1'b0;
        end
        if (q.enq_valid && ((count_r < CW'(DEPTH)) || deq_fire_s)) begin
            enq_fire_s = 1'b1;
        end else if (q.enq_valid) begin
            drop_s = 1'b1;
        end else begin
            enq_fire_s = 1'b0;
        end
    end

    // Payload storage, intentionally left unreset.
    always_ff @(posedge clk) begin
        if (enq_fire_s && !flush) begin
            mem_r[tail_r] <= q.enq_data;
        end
    end

    // Pointer, occupancy and sticky error state; flush outranks all traffic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_r     <= PW'(0);
            tail_r     <= PW'(0);
            count_r    <= CW'(0);
            overflow_r <= 1'b0;
        end else if (flush) begin
            head_r     <= PW'(0);
            tail_r     <= PW'(0);
            count_r    <= CW'(0);
        end else begin
            if (deq_fire_s) begin
                head_r <= head_r + PW'(1);
            end
            if (enq_fire_s) begin
                tail_r <= tail_r + PW'(1);
            end
            case ({enq_fire_s, deq_fire_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign q.deq_valid  = (count_r != CW'(0));
    assign q.deq_data   = mem_r[head_r];
    assign q.queue_full = (count_r >= CW'(DEPTH - SKID));
    assign count        = count_r;
    assign overflow     = overflow_r;

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameter: DEPTH, default 8, number of entries; power of two, minimum 4.
REQ-002 Parameter: SKID, default 2, free entries kept in reserve behind queue_full to absorb the in-flight fetch->issue pipeline stage.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 enq_valid  input  1  fetch->issue register holds a valid instruction this cycle.
REQ-006 enq_data  input  pipe_in_t  instruction payload from the fetch->issue register (structs.svh).
REQ-007 queue_full  output  1  back-pressure to fetch: stop fetching.
REQ-008 deq_valid  output  1  head entry is valid.
REQ-009 deq_data  output  pipe_in_t  head entry payload.
REQ-010 deq_ready  input  1  dispatch/rename accepts the head entry this cycle.
REQ-011 flush  input  1  synchronous discard of all queued entries (mispredict recovery).
REQ-012 count  output  $clog2(DEPTH+1)  number of valid entries.
REQ-013 overflow  output  1  sticky error flag: an enqueue was dropped.

Function
REQ-014 Storage is a circular buffer of DEPTH pipe_in_t entries, with head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-015 Dequeue fire is deq_valid && deq_ready; fire advances head by 1.
REQ-016 Enqueue fire is enq_valid && (count < DEPTH || dequeue fire); fire writes enq_data at tail and advances tail by 1.
REQ-017 Count update per edge: +1 on enqueue fire only, -1 on dequeue fire only, unchanged on both or neither.
REQ-018 Simultaneous enqueue and dequeue are legal at every occupancy: when empty, enqueue only (no dequeue possible); when full, both proceed and count stays DEPTH.
REQ-019 deq_valid = (count != 0); deq_data is the entry at head, first-word-fall-through, driven from storage with no extra register stage.
REQ-020 No enqueue-to-dequeue bypass: an entry enqueued at edge N is visible on deq_data no earlier than the cycle after edge N.
REQ-021 queue_full = (count >= DEPTH - SKID); combinational from count.
REQ-022 enq_valid with count == DEPTH and no dequeue fire: entry dropped, storage and pointers unchanged, overflow set to 1.
REQ-023 overflow is sticky; only reset clears it, and flush does not clear it.
REQ-024 Flush has priority over everything: at the edge, head = tail = 0 and count = 0; same-cycle enqueue and dequeue are ignored, and no overflow is set for that cycle.
REQ-025 deq_data is don't-care while deq_valid = 0; the bench does not check it.
REQ-026 Entries leave in strict arrival order; no entry is duplicated or lost except through REQ-022 or REQ-024.

Reset
REQ-027 While reset = 0: head = 0, tail = 0, count = 0, overflow = 0, deq_valid = 0, queue_full = 0, applied asynchronously without waiting for a clock edge.
REQ-028 Storage contents are not reset.
REQ-029 Reset asserted mid-operation discards all entries immediately.
REQ-030 First enqueue is accepted on the first rising edge after reset deasserts.

Verification
REQ-031 Reset, then enqueue A,B,C on consecutive cycles with deq_ready = 0 -> count = 3; deq_valid rises the cycle after A; deq_data = A.
REQ-032 DEPTH = 8, SKID = 2, fill with no dequeue -> queue_full rises when count reaches 6; enqueues 7 and 8 are accepted; 9th enqueue is dropped, overflow = 1, count = 8.
REQ-033 Full queue, enq_valid = 1 and deq_ready = 1 for 20 cycles -> count holds 8, output order matches input order across pointer wrap, overflow stays 0.
REQ-034 count = 5, flush = 1 together with enq_valid = 1 and deq_ready = 1 -> next cycle count = 0, deq_valid = 0, queue_full = 0; next enqueue appears at deq_data one cycle later.
REQ-035 Reset pulsed low between clock edges with count = 4 and overflow = 1 -> count, overflow and deq_valid go to 0 before the next edge.
REQ-036 Random enq_valid/deq_ready (10k cycles) against a scoreboard -> no reorder, loss or duplication; count never exceeds DEPTH.
